// File: rtl/relu_pool22_if.sv
// Stream interface between the 5x5 convolution stage and the ReLU/2x2 max-pool stage.
// The master drives samples and per-map bias; the slave returns pooled pixels.
interface relu_pool22_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                        start;
  logic                        conv_valid;
  logic signed [IN_WIDTH-1:0]  conv_data;
  logic signed [IN_WIDTH-1:0]  bias;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        frame_done;

  modport master (
    output start, conv_valid, conv_data, bias,
    input  out_valid, out_data, frame_done
  );

  modport slave (
    input  start, conv_valid, conv_data, bias,
    output out_valid, out_data, frame_done
  );
endinterface

// File: rtl/relu_pool22.sv
// Bias + ReLU + shift/saturate requantisation followed by 2x2 stride-2 max pooling
// over one raster-ordered feature map, using a half-width line buffer.
module relu_pool22 #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CONV_SIZE = 28,
  parameter int SHIFT     = 0
) (
  input  logic          clk,
  input  logic          rst,
  relu_pool22_if.slave  bus
);

  // Counter width is kept at >= 2 so the line-buffer index col[CW-1:1] always exists.
  localparam int CW       = (CONV_SIZE > 2) ? $clog2(CONV_SIZE) : 2;
  localparam int LB_DEPTH = 2 ** (CW - 1);
  localparam logic [CW-1:0]        LAST = CW'(CONV_SIZE - 1);
  localparam logic [OUT_WIDTH-1:0] QMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic [CW-1:0]        col;
  logic [CW-1:0]        row;
  logic [OUT_WIDTH-1:0] hmax;
  logic [OUT_WIDTH-1:0] linebuf [LB_DEPTH];

  logic signed [IN_WIDTH:0] sum;
  logic [IN_WIDTH-1:0]      relu_mag;
  logic [IN_WIDTH-1:0]      shifted;
  logic [OUT_WIDTH-1:0]     q;
  logic [OUT_WIDTH-1:0]     h;
  logic [OUT_WIDTH-1:0]     above;
  logic [OUT_WIDTH-1:0]     pooled;
  logic [CW-2:0]            lb_idx;

  assign lb_idx = col[CW-1:1];
  assign above  = linebuf[lb_idx];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    sum      = '0;
    relu_mag = '0;
    shifted  = '0;
    q        = '0;
    h        = '0;
    pooled   = '0;
    // One extra bit on the sum means two extreme operands cannot wrap negative.
    sum = {bus.conv_data[IN_WIDTH-1], bus.conv_data} + {bus.bias[IN_WIDTH-1], bus.bias};
    if (!sum[IN_WIDTH]) relu_mag = sum[IN_WIDTH-1:0];
    // The ReLU result is non-negative, so a logical shift equals the arithmetic one.
    shifted = relu_mag >> SHIFT;
    if (|shifted[IN_WIDTH-1:OUT_WIDTH-1]) q = QMAX;
    else                                  q = shifted[OUT_WIDTH-1:0];
    h      = (q > hmax) ? q : hmax;
    pooled = (above > h) ? above : h;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col            <= '0;
      row            <= '0;
      hmax           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
      // NOTE: the line buffer is cleared on reset, so it must stay in flops rather than RAM.
      for (int i = 0; i < LB_DEPTH; i++) linebuf[i] <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.start) begin
        col <= '0;
        row <= '0;
      end else if (bus.conv_valid) begin
        if (!col[0]) begin
          hmax <= q;
        end else if (!row[0]) begin
          linebuf[lb_idx] <= h;
        end else begin
          bus.out_data   <= pooled;
          bus.out_valid  <= 1'b1;
          bus.frame_done <= (col == LAST) && (row == LAST);
        end

        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/relu_pool22.md
Name: relu_pool22

Overview:
- Downstream neighbour of the 5x5 convolution stage.
- Consumes the stream of valid convolution results for one feature map in raster order.
- Per sample: adds a per-map bias, applies ReLU, then requantises by an arithmetic right shift with saturation.
- Performs 2x2 stride-2 max pooling using a half-width line buffer and emits pooled pixels for the next convolution layer's shift-register input.

Parameters:
- IN_WIDTH, 32, width of the signed convolution result and of the bias.
- OUT_WIDTH, 8, width of the pooled output pixel.
- CONV_SIZE, 28, width and height of the convolution output map. Must be even and ≥2.
- SHIFT, 0, arithmetic right shift applied after ReLU (fixed-point rescale).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  synchronous active-high frame restart; clears position counters.
- conv_valid  input  1  conv_data holds a valid convolution result this cycle.
- conv_data  input  IN_WIDTH signed  convolution result, raster order, row-major.
- bias  input  IN_WIDTH signed  bias added to every sample; static during a frame.
- out_valid  output  1  pooled pixel valid (one-cycle strobe).
- out_data  output  OUT_WIDTH signed  pooled pixel, always in [0, 2^(OUT_WIDTH-1)-1].
- frame_done  output  1  one-cycle strobe coincident with the last out_valid of a frame.

Behaviour:
- Reset: asserting rst (low) asynchronously clears col, row, the horizontal-max register, all line-buffer entries, out_valid, out_data and frame_done to 0. Mid-frame reset discards the partial frame; the next accepted sample is treated as (row 0, col 0).
- Counters:
  - col runs 0..CONV_SIZE-1; row runs 0..CONV_SIZE-1. Both advance only on an accepted sample (conv_valid=1 and start=0).
  - col wraps to 0 and increments row. At (CONV_SIZE-1, CONV_SIZE-1) both wrap to 0, and the next frame needs no start.
- start=1: col and row clear to 0 on that edge. A conv_valid sample in the same cycle is dropped. out_valid and frame_done are 0 in the following cycle. Line-buffer contents are not cleared; they are always overwritten before being read.
- Per-sample quantisation (combinational):
  - s = conv_data + bias, computed at IN_WIDTH+1 bits, with no wrap.
  - r = (s < 0) ? 0 : s.
  - q = r >>> SHIFT.
  - if q > 2^(OUT_WIDTH-1)-1, q saturates to 2^(OUT_WIDTH-1)-1.
- Pooling:
  - Even col: hmax register ← q.
  - Odd col: h = max(hmax, q).
  - Even row, odd col: linebuf[col>>1] ← h. No output.
  - Odd row, odd col: out_data ← max(linebuf[col>>1], h); out_valid ← 1 on the next edge.
- Latency: out_valid is registered and asserts exactly 1 cycle after the accepted sample at (odd row, odd col). out_data holds its value until the next output; out_valid is high for a single cycle.
- frame_done = 1 in the same cycle as the out_valid produced by sample (CONV_SIZE-1, CONV_SIZE-1).
- Gaps: conv_valid may deassert for any number of cycles at any point. State holds during gaps. No backpressure; an output is never dropped or delayed.
- Output count per frame: (CONV_SIZE/2)^2 pixels, in raster order.
- bias is sampled with each accepted sample; a change mid-frame affects subsequent samples only.

Test Plan:
- Reset: hold rst=0 with random inputs → out_valid=0, out_data=0, frame_done=0. Release rst; no out_valid occurs until 4 samples (2 rows × 2 cols at CONV_SIZE=2) are accepted.
- CONV_SIZE=4, bias=0, SHIFT=0, conv_data=0..15 ramp back-to-back → outputs 5, 7, 13, 15, each 1 cycle after samples 5, 7, 13, 15. frame_done fires with 15.
- CONV_SIZE=4, conv_data=-10 for all 16 samples, bias=0 → four outputs of 0. Repeat with bias=+13 → four outputs of 3.
- Saturation/shift: conv_data=1000, bias=0, SHIFT=0 → 127. SHIFT=3 → 125. conv_data=0x7FFFFFFF, bias=0x7FFFFFFF → 127 (no wrap).
- Gapped conv_valid (random 0–5 idle cycles) on the ramp → identical output sequence, each output 1 cycle after its triggering sample. start asserted after sample 6 with conv_valid=1 → that sample is dropped and the next 16 samples yield a clean frame.
- Two back-to-back frames with no start → 8 outputs and 2 frame_done pulses. rst pulse mid-second-frame → no output until a fresh 16-sample frame, whose results are correct.
